// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch PC unit: FSM states, NOP word and reset PC.
package fetch_pc_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_unit_pc_plus4_adder.sv
// Sequential-PC adder: PC + 4, wrapping modulo 2^32.
module pc_plus4_adder
  import fetch_pc_unit_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
);

  assign pc_plus4 = pc + XLEN'(4);

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction fetch PC unit: one outstanding imem read, holds the fetched word
// until decode accepts it, and handles redirects including misaligned targets.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] PCTarget,
  input  logic            PCSrc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] Instr,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic            misalign_fault
);

  fetch_state_e    state, state_n;
  logic [XLEN-1:0] pc_q, pc_n;
  logic [XLEN-1:0] instr_q, instr_n;
  logic [XLEN-1:0] pc_plus4;
  logic            redirect_ok, redirect_bad;

  pc_plus4_adder u_pc_plus4_adder (
    .pc       (pc_q),
    .pc_plus4 (pc_plus4)
  );

  assign redirect_ok  = PCSrc && (PCTarget[1:0] == 2'b00);
  assign redirect_bad = PCSrc && (PCTarget[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_REQ;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
    end else begin
      state   <= state_n;
      pc_q    <= pc_n;
      instr_q <= instr_n;
    end
  end

  // Redirect outranks ack and transfer; a concurrent transfer still completes on the decode side.
  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    instr_n = instr_q;
    if (redirect_ok) begin
      pc_n    = PCTarget;
      state_n = ST_REQ;
    end else if (redirect_bad) begin
      state_n = ST_FAULT;
    end else begin
      case (state)
        ST_REQ: begin
          if (imem_ack) begin
            instr_n = imem_rdata;
            state_n = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (instr_ready) begin
            pc_n    = pc_plus4;
            state_n = ST_REQ;
          end
        end
        ST_FAULT: ;
        default:  state_n = ST_REQ;
      endcase
    end
  end

  // Status decodes are masked while reset is held so nothing leaks before the first edge.
  assign imem_req       = (state == ST_REQ)   && !rst;
  assign instr_valid    = (state == ST_HOLD)  && !rst;
  assign misalign_fault = (state == ST_FAULT) && !rst;
  assign imem_addr      = pc_q;
  assign PC             = pc_q;
  assign PCPlus4        = pc_plus4;
  assign Instr          = instr_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: abstract fetch-stream model plus directed cases.
module tb_fetch_pc_unit;

  logic        clk;
  logic        rst;
  logic [31:0] PCTarget;
  logic        PCSrc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        misalign_fault;

  logic        rst2, req2, ack2, valid2, fault2;
  logic [31:0] addr2, instr2, pc2, pcp2;

  fetch_pc_unit dut (
    .clk(clk), .rst(rst), .PCTarget(PCTarget), .PCSrc(PCSrc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4), .misalign_fault(misalign_fault)
  );

  assign ack2 = req2;

  fetch_pc_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_top (
    .clk(clk), .rst(rst2), .PCTarget(32'h0000_0000), .PCSrc(1'b0),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2),
    .imem_rdata(32'h1234_5678), .instr_valid(valid2), .instr_ready(1'b1),
    .Instr(instr2), .PC(pc2), .PCPlus4(pcp2), .misalign_fault(fault2)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        q[$];
  exp_t        e_mon, e_drv;
  int          checks = 0;
  int          failures = 0;
  int          n_xfer = 0;
  bit          mon_en = 0;
  bit          pending = 0;
  bit          fault_cur = 0, fault_nxt = 0;
  logic [31:0] model_pc_cur = 0, model_pc_nxt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 ^ (a * 32'h9E37_79B1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, answer as memory, advance the fetch-stream model.
  task automatic step(input bit r, input bit ack_en, input bit rdy, input bit src,
                      input logic [31:0] tgt);
    bit xfer;
    @(negedge clk);
    model_pc_cur = model_pc_nxt;
    fault_cur    = fault_nxt;
    rst          = r;
    instr_ready  = rdy;
    PCSrc        = src;
    PCTarget     = tgt;
    imem_ack     = 1'b0;
    #1;
    imem_rdata = mem_word(imem_addr);
    imem_ack   = ack_en && (imem_req || r);
    if (r) begin
      q.delete();
      q.push_back('{32'h0, mem_word(32'h0)});
      pending      = 1;
      model_pc_nxt = 32'h0;
      fault_nxt    = 0;
    end else begin
      xfer = pending && instr_valid && rdy;
      if (xfer) pending = 0;
      if (src) begin
        if (pending) begin
          e_drv   = q.pop_back();
          pending = 0;
        end
        if (tgt[1:0] == 2'b00) begin
          model_pc_nxt = tgt;
          fault_nxt    = 0;
          q.push_back('{tgt, mem_word(tgt)});
          pending = 1;
        end else begin
          fault_nxt = 1;
        end
      end else if (xfer) begin
        model_pc_nxt = model_pc_cur + 32'd4;
        q.push_back('{model_pc_nxt, mem_word(model_pc_nxt)});
        pending = 1;
      end
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (mon_en && !rst) begin
      chk("pc", PC, model_pc_cur);
      chk("pcplus4", PCPlus4, model_pc_cur + 32'd4);
      chk("imem_addr", imem_addr, model_pc_cur);
      chk("fault_flag", 32'(misalign_fault), 32'(fault_cur));
      if (fault_cur) chk("fault_idle", 32'({imem_req, instr_valid}), 32'h0);
      else           chk("req_or_valid", 32'({imem_req, instr_valid}), 32'(imem_req ? 2'b10 : 2'b01));
      if (instr_valid && instr_ready) begin
        n_xfer++;
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL xfer_unexpected actual=pc %h required=no transfer", PC);
        end else begin
          e_mon = q.pop_front();
          chk("xfer_instr", Instr, e_mon.instr);
          chk("xfer_pc", PC, e_mon.pc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t;
    bit          r;
    rst = 1; rst2 = 1; PCSrc = 0; PCTarget = 0; imem_ack = 0; imem_rdata = 0; instr_ready = 0;

    // Top-of-memory reset PC: one fetch then wrap to zero.
    repeat (2) @(negedge clk);
    rst2 = 0;
    #3;
    chk("wrap_req", 32'(req2), 32'h1);
    chk("wrap_pc_init", pc2, 32'hFFFF_FFFC);
    chk("wrap_pcp4_init", pcp2, 32'h0);
    @(negedge clk); #3;
    chk("wrap_valid", 32'(valid2), 32'h1);
    @(negedge clk); #3;
    chk("wrap_pc", pc2, 32'h0);
    chk("wrap_pcp4", pcp2, 32'h4);
    chk("wrap_nofault", 32'(fault2), 32'h0);
    rst2 = 1;

    mon_en = 1;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    #2;
    chk("rst_pc", PC, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_instr", Instr, 32'h0000_0013);
    chk("rst_fault", 32'(misalign_fault), 32'h0);

    step(0, 1, 1, 0, 0);
    #2;
    chk("first_req", 32'(imem_req), 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    step(0, 0, 1, 0, 0);
    #2;
    chk("lat_valid", 32'(instr_valid), 32'h1);
    chk("first_instr", Instr, 32'h0050_0093);
    chk("first_pc", PC, 32'h0);
    step(0, 1, 0, 0, 0);
    #2;
    chk("next_addr", imem_addr, 32'h4);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 0);
      #2;
      chk("stall_instr", Instr, mem_word(32'h4));
      chk("stall_pc", PC, 32'h4);
      chk("stall_req", 32'(imem_req), 32'h0);
    end
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    #2;
    chk("stall_adv", PC, 32'h8);

    step(0, 0, 0, 1, 32'h40);
    #2;
    chk("redir_hold", 32'(instr_valid), 32'h1);
    step(0, 0, 0, 0, 0);
    #2;
    chk("redir_valid", 32'(instr_valid), 32'h0);
    chk("redir_addr", imem_addr, 32'h40);

    step(0, 1, 0, 1, 32'h42);
    step(0, 0, 0, 0, 0);
    #2;
    chk("mis_fault", 32'(misalign_fault), 32'h1);
    chk("mis_req", 32'(imem_req), 32'h0);
    chk("mis_pc", PC, 32'h40);
    step(0, 0, 0, 1, 32'h43);
    step(0, 0, 0, 1, 32'h80);
    #2;
    chk("mis_sticky", 32'(misalign_fault), 32'h1);
    step(0, 0, 0, 0, 0);
    #2;
    chk("mis_clear", 32'(misalign_fault), 32'h0);
    chk("mis_addr", imem_addr, 32'h80);

    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    #2;
    chk("rst_ack_instr", Instr, 32'h0000_0013);
    chk("rst_ack_valid", 32'(instr_valid), 32'h0);
    chk("rst_ack_pc", PC, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 249) == 0);
      t = $urandom();
      if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF8;
      if ($urandom_range(0, 4) != 0) t[1:0] = 2'b00;
      step(r, $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 6,
           $urandom_range(0, 9) == 0, t);
    end

    @(negedge clk);
    mon_en = 0;
    #3;
    chk("sb_leftover", 32'(q.size() <= 1), 32'h1);
    chk("xfer_count", 32'(n_xfer > 100), 32'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter RESET_PC SHALL default to 32'h0000_0000 and give the PC loaded on reset.
REQ-002 Port clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst  in  1  SHALL be the reset, synchronous and active-high.
REQ-004 Port PCTarget  in  32  SHALL be the branch/jump target from the target adder.
REQ-005 Port PCSrc  in  1  SHALL, when 1, request a redirect to PCTarget in that cycle.
REQ-006 Port imem_req  out  1  SHALL request an instruction-memory read.
REQ-007 Port imem_addr  out  32  SHALL be the read address; always equals PC.
REQ-008 Port imem_ack  in  1  SHALL indicate imem_rdata is valid for the current request; same-cycle ack allowed.
REQ-009 Port imem_rdata  in  32  SHALL be the instruction word returned by memory.
REQ-010 Port instr_valid  out  1  SHALL indicate Instr/PC hold a fetched instruction for decode.
REQ-011 Port instr_ready  in  1  SHALL indicate decode accepts Instr this cycle.
REQ-012 Port Instr  out  32  SHALL be the held instruction word.
REQ-013 Port PC  out  32  SHALL be the address of the current fetch / held instruction.
REQ-014 Port PCPlus4  out  32  SHALL equal PC + 4 combinationally, modulo 2^32.
REQ-015 Port misalign_fault  out  1  SHALL flag a redirect to a non-word-aligned target.

Function
REQ-016 FSM states SHALL be REQ, HOLD, FAULT.
REQ-017 REQ: imem_req=1, instr_valid=0; on imem_ack capture imem_rdata into Instr and go to HOLD.
REQ-018 HOLD: imem_req=0, instr_valid=1; Instr and PC stable until transfer (instr_valid & instr_ready).
REQ-019 On transfer without redirect, PC SHALL load PCPlus4 and FSM go to REQ.
REQ-020 Redirect (PCSrc=1) in REQ or HOLD with PCTarget[1:0]==0 SHALL load PC<=PCTarget and go to REQ, discarding any held instruction or same-cycle ack.
REQ-021 Redirect with PCTarget[1:0]!=0 SHALL go to FAULT, leaving PC unchanged.
REQ-022 FAULT: imem_req=0, instr_valid=0, misalign_fault=1; sticky until rst or an aligned redirect, which behaves as REQ-020.
REQ-023 Simultaneous transfer and redirect: transfer completes (decode keeps the word); redirect wins for next PC.
REQ-024 Increment at PC=32'hFFFF_FFFC SHALL wrap to 32'h0000_0000 with no flag.
REQ-025 Latency: ack in cycle N -> instr_valid=1 in N+1; minimum 2 cycles per instruction.
REQ-026 imem_addr SHALL never change while imem_req=1 and no ack/redirect has occurred.

Reset
REQ-027 While rst=1: PC=RESET_PC, FSM=REQ, imem_req=0, instr_valid=0, Instr=32'h0000_0013 (NOP), misalign_fault=0.
REQ-028 First cycle after rst deasserts SHALL assert imem_req with imem_addr=RESET_PC.
REQ-029 rst mid-operation SHALL drop any outstanding request/held instruction; a late ack is ignored.

Structure
REQ-030 Shared package SHALL hold the FSM state enum, the NOP constant 32'h0000_0013, and the RESET_PC default.
REQ-031 One sub-module, pc_plus4_adder (PC -> PC+4), SHALL be instantiated; the rest is flat.

Verification
REQ-032 Reset then ack next cycle with rdata 32'h0050_0093, ready=1 -> Instr=32'h0050_0093, PC=0, then imem_addr=4.
REQ-033 In HOLD at PC=8, PCSrc=1, PCTarget=32'h0000_0040 -> instr_valid=0 next cycle, imem_addr=32'h40.
REQ-034 PCTarget=32'h0000_0042 with PCSrc=1 -> misalign_fault=1, imem_req=0; later PCTarget=32'h80 -> fault clears, imem_addr=32'h80.
REQ-035 instr_ready=0 for 5 cycles in HOLD -> Instr/PC stable, imem_req=0; ready=1 -> PC advances by 4.
REQ-036 RESET_PC=32'hFFFF_FFFC, one transfer -> PC=0, PCPlus4=4.
REQ-037 rst pulsed during REQ with ack arriving same cycle -> Instr=NOP, instr_valid=0, PC=RESET_PC.
